axis_egress_rate_limiter: RTL

- Per-port token-bucket shaper placed directly downstream of one output-queue master stream (m_axis_*_N), before the TX queue / MAC.
- Gates packets at start-of-packet by byte credit, then passes the rest of the packet with zero added latency.
- Exposes pulse and count signals for the port's statistics registers.
- One instance per port. Configuration comes from the parent's rw_regs.

---
 rtl/axis_egress_rate_limiter.sv | 115 +++++++++++
 1 files changed

// File: rtl/axis_egress_rate_limiter.sv
// Per-port token-bucket egress shaper: holds each packet at its first beat until
// the bucket covers its length, then forwards the remaining beats with no added latency.
module axis_egress_rate_limiter #(
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int C_TOKEN_WIDTH        = 32
) (
    input  logic                               axi_aclk,
    input  logic                               axi_reset,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]     s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]   s_axis_tstrb,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]    s_axis_tuser,
    input  logic                               s_axis_tvalid,
    output logic                               s_axis_tready,
    input  logic                               s_axis_tlast,

    output logic [C_M_AXIS_DATA_WIDTH-1:0]     m_axis_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]   m_axis_tstrb,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]    m_axis_tuser,
    output logic                               m_axis_tvalid,
    input  logic                               m_axis_tready,
    output logic                               m_axis_tlast,

    input  logic                               cfg_enable,
    input  logic [C_TOKEN_WIDTH-1:0]           cfg_rate,
    input  logic [C_TOKEN_WIDTH-1:0]           cfg_bucket_max,
    output logic [C_TOKEN_WIDTH-1:0]           tokens,
    output logic                               pkt_passed,
    output logic [C_TOKEN_WIDTH-1:0]           throttle_cycles
);

    localparam int TW = C_TOKEN_WIDTH;

    // Handshake: a beat transfers on a cycle where tvalid and tready are both high.
    // tready never waits on tvalid; in IDLE both sides are additionally gated by admit.
    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [TW-1:0] pkt_len;
    logic [TW-1:0] len_eff;
    logic          admit;
    logic          beat_hs;
    logic [TW-1:0] deduct;
    logic [TW:0]   token_sum;
    logic [TW-1:0] tokens_next;

    assign m_axis_tdata = s_axis_tdata;
    assign m_axis_tstrb = s_axis_tstrb;
    assign m_axis_tuser = s_axis_tuser;
    assign m_axis_tlast = s_axis_tlast;

    assign pkt_len = TW'(s_axis_tuser[15:0]);
    // Oversized packets are charged a full bucket so they can never stall forever.
    assign len_eff = (pkt_len > cfg_bucket_max) ? cfg_bucket_max : pkt_len;
    assign admit   = ~cfg_enable | (tokens >= len_eff);

    always_comb begin
        state_next    = state;
        m_axis_tvalid = 1'b0;
        s_axis_tready = 1'b0;
        beat_hs       = 1'b0;
        deduct        = '0;
        case (state)
            IDLE: begin
                m_axis_tvalid = s_axis_tvalid & admit;
                s_axis_tready = m_axis_tready & admit;
                beat_hs       = s_axis_tvalid & m_axis_tready & admit;
                if (beat_hs) begin
                    if (cfg_enable) deduct = len_eff;
                    if (!s_axis_tlast) state_next = SEND;
                end
            end
            SEND: begin
                m_axis_tvalid = s_axis_tvalid;
                s_axis_tready = m_axis_tready;
                beat_hs       = s_axis_tvalid & m_axis_tready;
                if (beat_hs && s_axis_tlast) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (axi_reset) begin
            m_axis_tvalid = 1'b0;
            s_axis_tready = 1'b0;
            beat_hs       = 1'b0;
        end
    end

    // deduct never exceeds tokens, so the subtraction cannot underflow.
    assign token_sum   = {1'b0, tokens} + {1'b0, cfg_rate} - {1'b0, deduct};
    assign tokens_next = (token_sum > {1'b0, cfg_bucket_max}) ? cfg_bucket_max
                                                               : token_sum[TW-1:0];

    always_ff @(posedge axi_aclk or posedge axi_reset) begin
        if (axi_reset) begin
            state           <= IDLE;
            tokens          <= '0;
            throttle_cycles <= '0;
            pkt_passed      <= 1'b0;
        end else begin
            state      <= state_next;
            tokens     <= tokens_next;
            pkt_passed <= beat_hs & s_axis_tlast;
            if (state == IDLE && s_axis_tvalid && !admit && throttle_cycles != '1)
                throttle_cycles <= throttle_cycles + TW'(1);
        end
    end

endmodule
